// File: rtl/aes_package.sv
// aes_package: shared TCDM bus constants, request bundle, response kinds and byte-mask helper
package aes_package;
  localparam int TCDM_DW = 32;
  localparam int TCDM_AW = 32;
  localparam logic [TCDM_DW-1:0] TCDM_ERR_WORD = 32'hDEAD_BEEF;
  typedef struct packed {
    logic [TCDM_AW-1:0]   add;
    logic                 wen;
    logic [TCDM_DW/8-1:0] be;
    logic [TCDM_DW-1:0]   data;
  } tcdm_req_t;
  typedef enum logic [1:0] {RSP_ZERO, RSP_BANK, RSP_ERR} rsp_kind_e;
  function automatic logic [TCDM_DW-1:0] be_mask(input logic [TCDM_DW/8-1:0] be);
    for (int i = 0; i < TCDM_DW/8; i++) be_mask[8*i +: 8] = {8{be[i]}};
  endfunction
endpackage

// File: rtl/aes_tcdm_bank.sv
// aes_tcdm_bank: single-port NR x 32 SRAM bank with byte-enable writes and registered read data
//   clk_i clock | en_i access strobe | we_i 1=write | be_i byte enables
//   row_i word row | wdata_i write data | rdata_o read data, valid the cycle after a read
module aes_tcdm_bank
  import aes_package::*;
#(
  parameter int NR = 256,
  parameter int RW = 8
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [RW-1:0]      row_i,
  input  logic [TCDM_DW-1:0] wdata_i,
  output logic [TCDM_DW-1:0] rdata_o
);
  logic [TCDM_DW-1:0] mem_q [NR];
  logic [TCDM_DW-1:0] rdata_q;
  logic [TCDM_DW-1:0] mask;
  assign mask = be_mask(be_i);
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) mem_q[row_i] <= (mem_q[row_i] & ~mask) | (wdata_i & mask);
    if (en_i && !we_i) rdata_q <= mem_q[row_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/aes_tcdm_responder.sv
// aes_tcdm_responder: MP-port TCDM slave over NB word-interleaved banks with RR arbitration
//   clk_i/rst_i clock, async active-high reset | tcdm_req/gnt handshake (gnt combinational)
//   tcdm_add/wen/be/data request fields | tcdm_r_data/r_valid 1-cycle response
//   stall_en_i random grant stalls | err_cnt_o saturating out-of-range access count
module aes_tcdm_responder
  import aes_package::*;
#(
  parameter int          MP        = 2,
  parameter int          NB        = 4,
  parameter int          NWORDS    = 1024,
  parameter logic [31:0] BASE      = 32'h1000_0000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [MP-1:0]       tcdm_req,
  output logic [MP-1:0]       tcdm_gnt,
  input  logic [MP-1:0][31:0] tcdm_add,
  input  logic [MP-1:0]       tcdm_wen,
  input  logic [MP-1:0][3:0]  tcdm_be,
  input  logic [MP-1:0][31:0] tcdm_data,
  output logic [MP-1:0][31:0] tcdm_r_data,
  output logic [MP-1:0]       tcdm_r_valid,
  input  logic                stall_en_i,
  output logic [15:0]         err_cnt_o
);
  localparam int NR = NWORDS / NB;
  localparam int RW = NR > 1 ? $clog2(NR) : 1;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = MP > 1 ? $clog2(MP) : 1;
  tcdm_req_t [MP-1:0]     rq;
  logic [MP-1:0]          in_rng, elig, won, rv_q, rv_d;
  logic [MP-1:0][BW-1:0]  bank, rb_q, rb_d;
  logic [MP-1:0][RW-1:0]  row;
  logic [MP-1:0][15:0]    lfsr_q, lfsr_d;
  logic [MP-1:0][1:0]     rk_q, rk_d;
  logic [NB-1:0][PW-1:0]  ptr_q, ptr_d, bwin;
  logic [NB-1:0]          bvld;
  logic [NB-1:0][MP-1:0]  cand;
  logic [NB-1:0][31:0]    brd;
  logic [15:0]            err_q, err_d;
  logic [16:0]            err_sum;
  for (genvar p = 0; p < MP; p++) begin : g_port
    logic [31:0] word;
    assign rq[p]     = '{add: tcdm_add[p], wen: tcdm_wen[p], be: tcdm_be[p], data: tcdm_data[p]};
    assign word      = (rq[p].add - BASE) >> 2;
    assign in_rng[p] = rq[p].add >= BASE && word < 32'(NWORDS);
    assign bank[p]   = BW'(word % 32'(NB));
    assign row[p]    = RW'(word / 32'(NB));
    assign elig[p]   = tcdm_req[p] && !(stall_en_i && lfsr_q[p][1:0] == 2'b00);
    assign lfsr_d[p] = {lfsr_q[p][14:0], lfsr_q[p][15] ^ lfsr_q[p][13] ^ lfsr_q[p][12] ^ lfsr_q[p][10]};
    // only reads carry data back; writes and dropped accesses answer with zero
    assign rk_d[p]   = !tcdm_gnt[p] || !rq[p].wen ? RSP_ZERO : in_rng[p] ? RSP_BANK : RSP_ERR;
    assign tcdm_r_data[p] = !rv_q[p] ? '0 : rk_q[p] == RSP_BANK ? brd[rb_q[p]] :
                            rk_q[p] == RSP_ERR ? TCDM_ERR_WORD : '0;
  end
  always_comb begin
    cand  = '0;
    bvld  = '0;
    bwin  = '0;
    won   = '0;
    ptr_d = ptr_q;
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < MP; p++) cand[b][p] = elig[p] && in_rng[p] && bank[p] == BW'(b);
      // circular scan from the bank pointer; first candidate found wins
      for (int i = 0; i < MP; i++)
        if (!bvld[b] && cand[b][(int'(ptr_q[b]) + i) % MP]) begin
          bvld[b] = 1'b1;
          bwin[b] = PW'((int'(ptr_q[b]) + i) % MP);
        end
      if (bvld[b]) begin
        won[bwin[b]] = 1'b1;
        ptr_d[b]     = PW'((int'(bwin[b]) + 1) % MP);
      end
    end
  end
  // out-of-range requests never touch a bank, so they are all granted
  assign tcdm_gnt = rst_i ? '0 : won | (elig & ~in_rng);
  assign rv_d     = tcdm_gnt;
  assign rb_d     = bank;
  assign err_sum  = {1'b0, err_q} + 17'($countones(tcdm_gnt & ~in_rng));
  assign err_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  for (genvar b = 0; b < NB; b++) begin : g_bank
    aes_tcdm_bank #(.NR(NR), .RW(RW)) u_bank (
      .clk_i   (clk_i),
      .en_i    (bvld[b] && !rst_i),
      .we_i    (!rq[bwin[b]].wen),
      .be_i    (rq[bwin[b]].be),
      .row_i   (row[bwin[b]]),
      .wdata_i (rq[bwin[b]].data),
      .rdata_o (brd[b])
    );
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < MP; p++) lfsr_q[p] <= LFSR_SEED ^ 16'(p);
      ptr_q <= '0;
      rv_q  <= '0;
      rk_q  <= '0;
      rb_q  <= '0;
      err_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      ptr_q  <= ptr_d;
      rv_q   <= rv_d;
      rk_q   <= rk_d;
      rb_q   <= rb_d;
      err_q  <= err_d;
    end
  end
  assign tcdm_r_valid = rv_q;
  assign err_cnt_o    = err_q;
endmodule

// File: tb/tb_aes_tcdm_responder.sv
// tb_aes_tcdm_responder: randomized self-checking bench against a word-level reference model
module tb_aes_tcdm_responder;
  localparam int MP = 2, NB = 4, NWORDS = 1024;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 0, rst, stall;
  logic [MP-1:0] req, gnt, wen, rv;
  logic [MP-1:0][31:0] add, data, rd;
  logic [MP-1:0][3:0] be;
  logic [15:0] err_cnt;
  logic [31:0] gmem [NWORDS];
  int ptr [NB];
  logic [15:0] lf [MP];
  int m_err, errors, checks;
  logic [MP-1:0] exp_gnt, obs_gnt, exp_rv, obs_rv;
  logic [MP-1:0][31:0] exp_rd, obs_rd;
  logic [15:0] obs_err;

  aes_tcdm_responder dut (
    .clk_i(clk), .rst_i(rst), .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add), .tcdm_wen(wen),
    .tcdm_be(be), .tcdm_data(data), .tcdm_r_data(rd), .tcdm_r_valid(rv), .stall_en_i(stall),
    .err_cnt_o(err_cnt)
  );
  always #5 clk = ~clk;

  function automatic bit oor(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 2) >= 32'(NWORDS));
  endfunction
  function automatic int wrd(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction
  function automatic logic [31:0] pick(input int p);
    return BASE + 32'((int'($urandom_range(0, 15)) * NB + (p == 0 ? 0 : 2) + int'($urandom_range(0, 1))) * 4);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    for (int p = 0; p < MP; p++) lf[p] = SEED ^ 16'(p);
    m_err = 0;
  endtask

  task automatic drive(input int p, input logic r, input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req[p] = r; add[p] = a; wen[p] = w; be[p] = b; data[p] = d;
  endtask

  // one clock of stimulus: predicts grants/responses from the rules, samples the DUT
  task automatic cyc();
    bit [MP-1:0] el;
    #1;
    obs_gnt = gnt;
    exp_gnt = '0;
    for (int p = 0; p < MP; p++) el[p] = req[p] && !(stall && lf[p][1:0] == 2'b00);
    for (int p = 0; p < MP; p++) if (el[p] && oor(add[p])) exp_gnt[p] = 1'b1;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < MP; i++) begin
        int p = (ptr[b] + i) % MP;
        if (el[p] && !oor(add[p]) && wrd(add[p]) % NB == b) begin
          exp_gnt[p] = 1'b1;
          ptr[b] = (p + 1) % MP;
          break;
        end
      end
    for (int p = 0; p < MP; p++) begin
      exp_rd[p] = '0;
      if (exp_gnt[p] && wen[p]) exp_rd[p] = oor(add[p]) ? 32'hDEAD_BEEF : gmem[wrd(add[p])];
    end
    for (int p = 0; p < MP; p++)
      if (exp_gnt[p] && !wen[p] && !oor(add[p]))
        for (int i = 0; i < 4; i++) if (be[p][i]) gmem[wrd(add[p])][8*i +: 8] = data[p][8*i +: 8];
    for (int p = 0; p < MP; p++) if (exp_gnt[p] && oor(add[p])) m_err++;
    if (m_err > 65535) m_err = 65535;
    exp_rv = exp_gnt;
    for (int p = 0; p < MP; p++) lf[p] = {lf[p][14:0], lf[p][15] ^ lf[p][13] ^ lf[p][12] ^ lf[p][10]};
    @(posedge clk);
    #1;
    obs_rv = rv; obs_rd = rd; obs_err = err_cnt;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; req = '0; add = '0; wen = '1; be = '0; data = '0;
    repeat (2) @(negedge clk);
    drive(0, 1, BASE, 1, 4'hF, 0); drive(1, 1, BASE + 32'h4, 1, 4'hF, 0);
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
    checks++; if (rv !== 2'b00 || rd !== '0) begin errors++; $display("FAIL reset_rsp: got rv=%b rd=%h exp 0", rv, rd); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err: got %h exp 0", err_cnt); end
    @(negedge clk);
    req = '0; rst = 0; model_reset();
  endtask

  task automatic test_write_read();
    drive(0, 1, BASE + 32'h10, 0, 4'hF, 32'hCAFE_BABE); drive(1, 0, 0, 1, 0, 0);
    cyc();
    checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b exp 01", obs_gnt); end
    checks++; if (obs_rv !== 2'b01 || obs_rd !== '0) begin errors++; $display("FAIL wr_rsp: got rv=%b rd=%h exp rv=01 rd=0", obs_rv, obs_rd); end
    drive(0, 1, BASE + 32'h10, 1, 4'hF, 0);
    cyc();
    checks++; if (obs_gnt !== 2'b01 || obs_rv !== 2'b01) begin errors++; $display("FAIL rd_hs: got gnt=%b rv=%b exp 01/01", obs_gnt, obs_rv); end
    checks++; if (obs_rd[0] !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd_data: got %h exp cafebabe", obs_rd[0]); end
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    checks++; if (obs_rv !== 2'b00 || obs_rd !== '0) begin errors++; $display("FAIL rv_pulse: got rv=%b rd=%h exp 0", obs_rv, obs_rd); end
  endtask

  task automatic test_byte_enable();
    drive(0, 1, BASE + 32'h20, 0, 4'hF, 32'h1122_3344); cyc();
    drive(0, 1, BASE + 32'h20, 0, 4'b0101, 32'hAABB_CCDD); cyc();
    drive(0, 1, BASE + 32'h20, 0, 4'b0000, 32'hFFFF_FFFF); cyc();
    checks++; if (obs_gnt !== 2'b01 || obs_rv !== 2'b01) begin errors++; $display("FAIL be0_ack: got gnt=%b rv=%b exp 01/01", obs_gnt, obs_rv); end
    drive(0, 1, BASE + 32'h20, 1, 4'hF, 0); cyc();
    checks++; if (obs_rd[0] !== 32'h11BB_33DD) begin errors++; $display("FAIL be_merge: got %h exp 11bb33dd", obs_rd[0]); end
    drive(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_conflict();
    drive(1, 1, BASE, 0, 4'hF, 32'h0BAD_F00D); cyc();
    for (int c = 0; c < 4; c++) begin
      logic [1:0] want;
      want = c[0] ? 2'b10 : 2'b01;
      drive(0, 1, BASE, 1, 4'hF, 0); drive(1, 1, BASE + 32'h10, 1, 4'hF, 0);
      cyc();
      checks++; if (obs_gnt !== want || obs_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt%0d: got %b exp %b", c, obs_gnt, want); end
      checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rr_data%0d: got %h exp %h", c, obs_rd, exp_rd); end
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, BASE, 0, 4'hF, $urandom); drive(1, 1, BASE + 32'h4, 0, 4'hF, $urandom);
      cyc();
      checks++; if (obs_gnt !== 2'b11) begin errors++; $display("FAIL par_gnt%0d: got %b exp 11", c, obs_gnt); end
    end
    drive(0, 1, BASE, 1, 4'hF, 0); drive(1, 1, BASE + 32'h4, 1, 4'hF, 0);
    cyc();
    checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL par_data: got %h exp %h", obs_rd, exp_rd); end
    drive(0, 0, 0, 1, 0, 0); drive(1, 0, 0, 1, 0, 0);
  endtask

  task automatic test_out_of_range();
    drive(0, 1, 32'h0FFF_FFFC, 1, 4'hF, 0); drive(1, 1, 32'h1000_1000, 0, 4'hF, 32'h1234_5678);
    cyc();
    checks++; if (obs_gnt !== 2'b11) begin errors++; $display("FAIL oor_gnt: got %b exp 11", obs_gnt); end
    checks++; if (obs_rd[0] !== 32'hDEAD_BEEF || obs_rd[1] !== 32'h0) begin errors++; $display("FAIL oor_data: got %h exp deadbeef/0", obs_rd); end
    checks++; if (obs_err !== 16'd2) begin errors++; $display("FAIL oor_err: got %0d exp 2", obs_err); end
    drive(0, 1, BASE, 1, 4'hF, 0); drive(1, 0, 0, 1, 0, 0);
    cyc();
    checks++; if (obs_rd[0] !== exp_rd[0]) begin errors++; $display("FAIL oor_mem: got %h exp %h", obs_rd[0], exp_rd[0]); end
    drive(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_stall();
    int g [MP];
    logic [31:0] a [MP];
    stall = 0;
    for (int w = 0; w < 64; w++) begin
      drive(0, 1, BASE + 32'(w * 4), 0, 4'hF, $urandom); drive(1, 0, 0, 1, 0, 0);
      cyc();
      checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL init_gnt%0d: got %b exp 01", w, obs_gnt); end
    end
    stall = 1;
    for (int p = 0; p < MP; p++) begin g[p] = 0; a[p] = pick(p); end
    for (int c = 0; c < 1000; c++) begin
      for (int p = 0; p < MP; p++) drive(p, 1, a[p], 1, 4'hF, 0);
      cyc();
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL stall_gnt%0d: got %b exp %b", c, obs_gnt, exp_gnt); end
      checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL stall_rv%0d: got %b exp %b", c, obs_rv, exp_rv); end
      checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL stall_rd%0d: got %h exp %h", c, obs_rd, exp_rd); end
      for (int p = 0; p < MP; p++) if (obs_gnt[p]) begin g[p]++; a[p] = pick(p); end
    end
    for (int p = 0; p < MP; p++) begin
      checks++; if (g[p] < 700 || g[p] > 800) begin errors++; $display("FAIL stall_ratio%0d: got %0d/1000 exp 700..800", p, g[p]); end
    end
  endtask

  task automatic test_random();
    logic [MP-1:0] act;
    logic [31:0] a;
    act = '0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < MP; p++)
        if (!act[p]) begin
          act[p] = $urandom_range(0, 3) != 0;
          a = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 32'h0FFF_FFF0 | 32'($urandom_range(0, 3)) : BASE + 32'h1000 + 32'($urandom_range(0, 255)))
                                        : BASE + 32'($urandom_range(0, 255));
          drive(p, act[p], a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
      cyc();
      checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt%0d: got %b exp %b", c, obs_gnt, exp_gnt); end
      checks++; if (obs_rv !== exp_rv || obs_rd !== exp_rd) begin errors++; $display("FAIL rnd_rsp%0d: got rv=%b rd=%h exp rv=%b rd=%h", c, obs_rv, obs_rd, exp_rv, exp_rd); end
      checks++; if (obs_err !== 16'(m_err)) begin errors++; $display("FAIL rnd_err%0d: got %0d exp %0d", c, obs_err, m_err); end
      for (int p = 0; p < MP; p++) if (obs_gnt[p]) act[p] = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    stall = 0;
    drive(0, 1, BASE, 1, 4'hF, 0); drive(1, 0, 0, 1, 0, 0); cyc();
    drive(0, 1, BASE + 32'h20, 0, 4'hF, 32'h5A5A_1234); cyc();
    checks++; if (obs_gnt !== 2'b01) begin errors++; $display("FAIL rm_pre: got %b exp 01", obs_gnt); end
    drive(0, 0, 0, 1, 0, 0); drive(1, 1, BASE + 32'h10, 1, 4'hF, 0);
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rm_gnt: got %b exp 10", gnt); end
    @(posedge clk);
    #1 rst = 1;
    #1;
    checks++; if (rv !== 2'b00 || rd !== '0) begin errors++; $display("FAIL rm_drop: got rv=%b rd=%h exp 0", rv, rd); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rm_gnt_rst: got %b exp 00", gnt); end
      @(posedge clk);
      #1;
      checks++; if (rv !== 2'b00) begin errors++; $display("FAIL rm_rv_rst: got %b exp 00", rv); end
    end
    @(negedge clk);
    rst = 0; req = '0; model_reset();
    cyc();
    checks++; if (obs_rv !== 2'b00 || obs_err !== 16'h0) begin errors++; $display("FAIL rm_after: got rv=%b err=%0d exp 0/0", obs_rv, obs_err); end
    drive(0, 1, BASE, 1, 4'hF, 0); drive(1, 1, BASE + 32'h20, 1, 4'hF, 0);
    cyc();
    checks++; if (obs_gnt !== 2'b01 || obs_rd !== exp_rd) begin errors++; $display("FAIL rm_ptr: got gnt=%b rd=%h exp 01 rd=%h", obs_gnt, obs_rd, exp_rd); end
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    checks++; if (obs_gnt !== 2'b10 || obs_rd[1] !== 32'h5A5A_1234) begin errors++; $display("FAIL rm_keep: got gnt=%b rd=%h exp 10 5a5a1234", obs_gnt, obs_rd[1]); end
    req = '0;
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_conflict();
    test_out_of_range();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
